// File: rtl/worktime_accumulator.sv
// worktime_accumulator: multi-channel BCD hh..:mm:ss run-time counters driven by
// a shared 1 Hz strobe, with sticky per-channel cleaning reminders and an
// optional saturate-at-maximum mode.
module worktime_accumulator #(
   parameter int CHANNELS    = 2,
   parameter int HOUR_DIGITS = 2,
   parameter int SAT_MODE    = 1,
   localparam int W          = 16 + 4*HOUR_DIGITS
) (
   input  logic                     clkout,
   input  logic                     rst,
   input  logic                     tick,
   input  logic [CHANNELS-1:0]      run,
   input  logic [CHANNELS-1:0]      clear,
   input  logic [4*HOUR_DIGITS-1:0] remind_hours,
   output logic [CHANNELS*W-1:0]    worktime,
   output logic [CHANNELS-1:0]      remind,
   output logic [CHANNELS-1:0]      saturated,
   output logic                     any_remind
);

   localparam int ND = 4 + HOUR_DIGITS;

   // Digit 1 (sec tens) and digit 3 (min tens) roll over at 5, all others at 9.
   function automatic logic [3:0] digit_max(input int unsigned k);
      return (k == 1 || k == 3) ? 4'd5 : 4'd9;
   endfunction

   function automatic logic [W-1:0] max_value();
      logic [W-1:0] r;
      r = '0;
      for (int unsigned k = 0; k < ND; k++) r[4*k +: 4] = digit_max(k);
      return r;
   endfunction

   // Ripple +1 through the digit chain; each digit clears on its carry-out.
   function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] v);
      logic [W-1:0] r;
      logic         c;
      r = v;
      c = 1'b1;
      for (int unsigned k = 0; k < ND; k++) begin
         if (c) begin
            if (r[4*k +: 4] == digit_max(k)) begin
               r[4*k +: 4] = '0;
            end else begin
               r[4*k +: 4] = r[4*k +: 4] + 4'd1;
               c = 1'b0;
            end
         end
      end
      return r;
   endfunction

   localparam logic [W-1:0] MAXV = max_value();

   logic [CHANNELS*W-1:0] worktime_q,  worktime_d;
   logic [CHANNELS-1:0]   remind_q,    remind_d;
   logic [CHANNELS-1:0]   saturated_q, saturated_d;

   // Per-channel next state: clear > tick&run increment > hold, then reminder update.
   always_comb begin
      logic [W-1:0] cur;
      logic [W-1:0] nxt;
      logic         rem_base;
      worktime_d  = worktime_q;
      remind_d    = remind_q;
      saturated_d = saturated_q;
      cur         = '0;
      nxt         = '0;
      rem_base    = 1'b0;
      for (int unsigned ch = 0; ch < CHANNELS; ch++) begin
         cur      = worktime_q[ch*W +: W];
         nxt      = cur;
         rem_base = remind_q[ch];
         if (clear[ch]) begin
            nxt             = '0;
            rem_base        = 1'b0;
            saturated_d[ch] = 1'b0;
         end else if (tick && run[ch]) begin
            if (cur == MAXV) begin
               if (SAT_MODE != 0) saturated_d[ch] = 1'b1;
               else               nxt = '0;
            end else begin
               nxt = bcd_inc(cur);
            end
         end
         worktime_d[ch*W +: W] = nxt;
         // Compare on post-update hours so the flag rises on the same edge.
         remind_d[ch] = rem_base |
                        ((remind_hours != '0) && (nxt[W-1:16] >= remind_hours));
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge clkout) begin
      if (rst) begin
         worktime_q  <= '0;
         remind_q    <= '0;
         saturated_q <= '0;
      end else begin
         worktime_q  <= worktime_d;
         remind_q    <= remind_d;
         saturated_q <= saturated_d;
      end
   end

   assign worktime   = worktime_q;
   assign remind     = remind_q;
   assign saturated  = saturated_q;
   assign any_remind = |remind_q;

endmodule

// File: tb/tb_worktime_accumulator.sv
// Directed bench for worktime_accumulator: one 2-hour-digit saturating instance
// plus 1-hour-digit saturating and wrapping instances for the maximum boundary.
module tb_worktime_accumulator;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, tick, tick_s;
   logic [1:0]  run, clear, run_s, clear_s;
   logic [7:0]  rh;
   logic [3:0]  rh_s;

   logic [47:0] wt;
   logic [1:0]  rem, sat;
   logic        anyr;
   logic [39:0] wt1, wt0;
   logic [1:0]  rem1, sat1, rem0, sat0;
   logic        any1, any0;

   worktime_accumulator #(.CHANNELS(2), .HOUR_DIGITS(2), .SAT_MODE(1)) u_main (
      .clkout(clk), .rst(rst), .tick(tick), .run(run), .clear(clear),
      .remind_hours(rh), .worktime(wt), .remind(rem), .saturated(sat),
      .any_remind(anyr));

   worktime_accumulator #(.CHANNELS(2), .HOUR_DIGITS(1), .SAT_MODE(1)) u_sat (
      .clkout(clk), .rst(rst), .tick(tick_s), .run(run_s), .clear(clear_s),
      .remind_hours(rh_s), .worktime(wt1), .remind(rem1), .saturated(sat1),
      .any_remind(any1));

   worktime_accumulator #(.CHANNELS(2), .HOUR_DIGITS(1), .SAT_MODE(0)) u_wrap (
      .clkout(clk), .rst(rst), .tick(tick_s), .run(run_s), .clear(clear_s),
      .remind_hours(rh_s), .worktime(wt0), .remind(rem0), .saturated(sat0),
      .any_remind(any0));

   typedef struct {
      string       tag;
      logic [47:0] exp;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;

   // Independent reference: seconds -> packed BCD hh:mm:ss (2 hour digits).
   function automatic logic [23:0] to_bcd(input int n);
      int h, m, s;
      h = n / 3600;
      m = (n / 60) % 60;
      s = n % 60;
      return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
   endfunction

   task automatic push(input string tag, input logic [47:0] e);
      sb.push_back('{tag, e});
   endtask

   task automatic chk(input logic [47:0] obs);
      exp_t e;
      total++;
      if (sb.size() == 0) begin
         bad++;
         $error("FAIL scoreboard_empty observed=%h expected=<entry>", obs);
         return;
      end
      e = sb.pop_front();
      assert (obs === e.exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b1; tick = 1'b1; run = 2'b11; clear = 2'b00; rh = 8'h00;
      tick_s = 1'b1; run_s = 2'b11; clear_s = 2'b00; rh_s = 4'h0;
      cyc(); cyc();
      push("rst_wt", 48'h0);    chk(wt);
      push("rst_rem", 48'h0);   chk({46'h0, rem});
      push("rst_sat", 48'h0);   chk({46'h0, sat});
      push("rst_any", 48'h0);   chk({47'h0, anyr});
      push("rst_wt1", 48'h0);   chk({8'h0, wt1});
      push("rst_wt0", 48'h0);   chk({8'h0, wt0});
      rst = 1'b0; tick = 1'b0; tick_s = 1'b0; run_s = 2'b00;

      // ch0 counts 59 s, ch1 idle; remind_hours=0 keeps reminders disabled
      run = 2'b01; tick = 1'b1;
      for (int i = 0; i < 59; i++) cyc();
      tick = 1'b0;
      push("sec59", {24'h0, 24'h000059});  chk(wt);
      push("rem_disabled", 48'h0);          chk({46'h0, rem});
      tick = 1'b1;
      push("pre_edge_hold", {24'h0, 24'h000059}); chk(wt);
      cyc();
      tick = 1'b0;
      push("min_roll", {24'h0, 24'h000100}); chk(wt);

      // count to 00:59:59 with periodic spot checks against the model
      tick = 1'b1;
      for (int n = 61; n <= 3599; n++) begin
         cyc();
         if (n % 997 == 0) begin
            push("count_spot", {24'h0, to_bcd(n)});
            chk(wt);
         end
      end
      tick = 1'b0;
      push("pre_hour", {24'h0, 24'h005959}); chk(wt);
      rh = 8'h01;
      cyc();
      push("rem_before_hour", 48'h0); chk({46'h0, rem});
      tick = 1'b1;
      cyc();
      tick = 1'b0;
      push("hour_roll", {24'h0, 24'h010000}); chk(wt);
      push("hour_rem", 48'h1);                chk({46'h0, rem});
      push("hour_any", 48'h1);                chk({47'h0, anyr});
      rh = 8'h05;
      cyc();
      push("rem_sticky", 48'h1); chk({46'h0, rem});

      // clear collides with tick on ch0; ch1 counts that tick
      run = 2'b11; clear = 2'b01; tick = 1'b1;
      cyc();
      clear = 2'b00; tick = 1'b0;
      push("clr_wt", {24'h000001, 24'h0}); chk(wt);
      push("clr_rem", 48'h0);              chk({46'h0, rem});
      push("clr_any", 48'h0);              chk({47'h0, anyr});

      // re-accumulate ch0 to 01:00:00 with threshold above it
      rh = 8'h10; run = 2'b01; tick = 1'b1;
      for (int i = 0; i < 3600; i++) cyc();
      tick = 1'b0; run = 2'b00;
      push("reacc_wt", {24'h000001, 24'h010000}); chk(wt);
      push("reacc_rem", 48'h0);                   chk({46'h0, rem});
      rh = 8'h01;
      cyc();
      push("lower_rem", 48'h1);                   chk({46'h0, rem});
      push("lower_wt", {24'h000001, 24'h010000}); chk(wt);

      // idle ticks with run=0
      tick = 1'b1;
      for (int i = 0; i < 100; i++) cyc();
      tick = 1'b0;
      push("idle_wt", {24'h000001, 24'h010000}); chk(wt);

      // maximum boundary on the 1-hour-digit instances (max 9:59:59)
      run_s = 2'b01; tick_s = 1'b1;
      for (int i = 0; i < 35999; i++) cyc();
      tick_s = 1'b0;
      push("max_sat", 48'h95959); chk({8'h0, wt1});
      push("max_wrap", 48'h95959); chk({8'h0, wt0});
      push("max_sat_flag", 48'h0); chk({46'h0, sat1});
      for (int t = 0; t < 3; t++) begin
         tick_s = 1'b1;
         cyc();
         tick_s = 1'b0;
         push("sat_hold", 48'h95959);           chk({8'h0, wt1});
         push("sat_flag", 48'h1);               chk({46'h0, sat1});
         push("wrap_val", 48'(t));              chk({8'h0, wt0});
         push("wrap_flag", 48'h0);              chk({46'h0, sat0});
      end

      total++;
      assert (sb.size() == 0) else begin
         bad++;
         $error("FAIL scoreboard_left observed=%0d expected=0", sb.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
